// File: rtl/intr_cfg_snoop_mc.sv
// ---------------------------------------------------------------------------
// intr_cfg_snoop_mc
// Passive snooper on the PCIe TRN RX stream. It decodes single-DW host
// memory writes (MWr32/MWr64, length 1) that hit BAR_IDX and keeps, for each
// of NUM_CH DMA channels, an interrupt enable bit and a 32-bit interrupt
// period. It only listens and never drives the TRN interface.
//
// Ports
//   trn_clk, reset_n       clock, asynchronous active-low reset
//   trn_rd[63:0]           RX data, DW0 in [63:32]
//   trn_rrem_n[7:0]        RX remainder (unused)
//   trn_rsof_n/trn_reof_n  start/end of frame, active-low
//   trn_rsrc_rdy_n         source ready, active-low
//   trn_rsrc_dsc_n         source discontinue, active-low
//   trn_rbar_hit_n[6:0]    BAR hit, active-low
//   trn_rdst_rdy_n         destination ready, active-low (observed only)
//   interrupts_enabled     per-channel enable
//   interrupt_period       channel c in bits [32c+31:32c]
//   cfg_update             one-cycle pulse per channel written
//
// Register map, per channel (DW index relative to REG_BASE + 4*ch):
//   +0 enable, +1 disable, +2 period (byte-swapped byte count), +3 reserved
// ---------------------------------------------------------------------------
module intr_cfg_snoop_mc #(
    parameter int          BAR_IDX    = 2,
    parameter int          NUM_CH     = 2,
    parameter int          REG_BASE   = 8,
    parameter logic        EN_RST     = 1'b1,
    parameter logic [31:0] PERIOD_RST = 32'h0003D090
) (
    input  logic                  trn_clk,
    input  logic                  reset_n,
    input  logic [63:0]           trn_rd,
    input  logic [7:0]            trn_rrem_n,
    input  logic                  trn_rsof_n,
    input  logic                  trn_reof_n,
    input  logic                  trn_rsrc_rdy_n,
    input  logic                  trn_rsrc_dsc_n,
    input  logic [6:0]            trn_rbar_hit_n,
    input  logic                  trn_rdst_rdy_n,
    output logic [NUM_CH-1:0]     interrupts_enabled,
    output logic [32*NUM_CH-1:0]  interrupt_period,
    output logic [NUM_CH-1:0]     cfg_update
);

    localparam logic [6:0] REG_LO = 7'(REG_BASE);
    localparam logic [6:0] REG_HI = 7'(REG_BASE + 4*NUM_CH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_COMMIT,
        S_DRAIN
    } state_t;

    state_t                   r_state, w_nxt;
    logic                     r_is64;
    logic [5:0]               r_idx;
    logic [NUM_CH-1:0]        r_en;
    logic [NUM_CH-1:0][31:0]  r_period;
    logic [NUM_CH-1:0]        r_upd;

    logic        w_acc, w_sof, w_eof, w_dsc;
    logic        w_qual;
    state_t      w_sof_nxt;
    logic        w_commit;
    logic [5:0]  w_idx;
    logic [31:0] w_data, w_sw;
    logic [6:0]  w_off;
    logic        w_in_rng;
    logic [2:0]  w_ch;
    logic [1:0]  w_sub;

    assign w_acc = !trn_rsrc_rdy_n && !trn_rdst_rdy_n;
    assign w_sof = !trn_rsof_n;
    assign w_eof = !trn_reof_n;
    assign w_dsc = !trn_rsrc_dsc_n;

    // Header qualifies: our BAR, MWr32 or MWr64, exactly one DW of payload.
    assign w_qual = !trn_rbar_hit_n[BAR_IDX] &&
                    (trn_rd[62:56] == 7'b10_00000 || trn_rd[62:56] == 7'b11_00000) &&
                    (trn_rd[41:32] == 10'd1);

    // Shared SOF handling for IDLE/COMMIT and for a restart inside ADDR/DATA.
    // A single-beat SOF+EOF frame carries nothing we care about.
    always_comb begin
        w_sof_nxt = S_IDLE;
        if (!w_eof)
            w_sof_nxt = w_qual ? S_ADDR : S_DRAIN;
    end

    // The data beat is the ADDR beat for MWr32 (must be EOF) or the DATA beat
    // for MWr64. Registers update on the edge that accepts it, so COMMIT is
    // the cycle where the new values and the pulse are visible.
    assign w_commit = w_acc && !w_dsc && !w_sof &&
                      ((r_state == S_ADDR && !r_is64 && w_eof) || r_state == S_DATA);

    assign w_idx  = (r_state == S_ADDR) ? trn_rd[39:34] : r_idx;
    assign w_data = (r_state == S_ADDR) ? trn_rd[31:0]  : trn_rd[63:32];
    assign w_sw   = {w_data[7:0], w_data[15:8], w_data[23:16], w_data[31:24]};

    assign w_in_rng = ({1'b0, w_idx} >= REG_LO) && ({1'b0, w_idx} < REG_HI);
    assign w_off    = {1'b0, w_idx} - REG_LO;
    assign w_ch     = w_off[4:2];
    assign w_sub    = w_off[1:0];

    always_comb begin
        w_nxt = r_state;
        if (w_acc) begin
            if (w_dsc) begin
                w_nxt = S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE, S_COMMIT: w_nxt = w_sof ? w_sof_nxt : S_IDLE;
                    S_ADDR: begin
                        if (w_sof)       w_nxt = w_sof_nxt;
                        else if (r_is64) w_nxt = w_eof ? S_IDLE : S_DATA;
                        else             w_nxt = w_eof ? S_COMMIT : S_DRAIN;
                    end
                    S_DATA:  w_nxt = w_sof ? w_sof_nxt : S_COMMIT;
                    S_DRAIN: w_nxt = w_eof ? S_IDLE : S_DRAIN;
                    default: w_nxt = S_IDLE;
                endcase
            end
        end else if (r_state == S_COMMIT) begin
            w_nxt = S_IDLE;
        end
    end

    always_ff @(posedge trn_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_is64  <= 1'b0;
            r_idx   <= '0;
        end else begin
            r_state <= w_nxt;
            if (w_acc && !w_dsc && w_sof)
                r_is64 <= trn_rd[61];
            if (w_acc && !w_dsc && !w_sof && r_state == S_ADDR)
                r_idx <= trn_rd[7:2];
        end
    end

    always_ff @(posedge trn_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_en     <= {NUM_CH{EN_RST}};
            r_period <= {NUM_CH{PERIOD_RST}};
            r_upd    <= '0;
        end else begin
            r_upd <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_commit && w_in_rng && w_ch == 3'(c)) begin
                    case (w_sub)
                        2'd0: begin r_en[c] <= 1'b1; r_upd[c] <= 1'b1; end
                        2'd1: begin r_en[c] <= 1'b0; r_upd[c] <= 1'b1; end
                        2'd2: begin
                            // Zero period would stall the channel; ignore it.
                            if (w_sw != 32'd0) begin
                                r_period[c] <= {2'b00, w_sw[31:2]};
                                r_upd[c]    <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign interrupts_enabled = r_en;
    assign interrupt_period   = r_period;
    assign cfg_update         = r_upd;

    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, trn_rrem_n, trn_rbar_hit_n};

endmodule

// File: tb/tb_intr_cfg_snoop_mc.sv
module tb_intr_cfg_snoop_mc;

    logic        trn_clk;
    logic        reset_n;
    logic [63:0] trn_rd;
    logic [7:0]  trn_rrem_n;
    logic        trn_rsof_n, trn_reof_n, trn_rsrc_rdy_n, trn_rsrc_dsc_n, trn_rdst_rdy_n;
    logic [6:0]  trn_rbar_hit_n;
    logic [1:0]  interrupts_enabled;
    logic [63:0] interrupt_period;
    logic [1:0]  cfg_update;

    intr_cfg_snoop_mc #(.BAR_IDX(2), .NUM_CH(2), .REG_BASE(8),
                        .EN_RST(1'b1), .PERIOD_RST(32'h0003D090)) dut (
        .trn_clk(trn_clk), .reset_n(reset_n), .trn_rd(trn_rd), .trn_rrem_n(trn_rrem_n),
        .trn_rsof_n(trn_rsof_n), .trn_reof_n(trn_reof_n), .trn_rsrc_rdy_n(trn_rsrc_rdy_n),
        .trn_rsrc_dsc_n(trn_rsrc_dsc_n), .trn_rbar_hit_n(trn_rbar_hit_n),
        .trn_rdst_rdy_n(trn_rdst_rdy_n), .interrupts_enabled(interrupts_enabled),
        .interrupt_period(interrupt_period), .cfg_update(cfg_update)
    );

    initial trn_clk = 1'b0;
    always #5 trn_clk = ~trn_clk;

    // Transaction-level model of the register file.
    logic [1:0]  m_en;
    logic [31:0] m_per [2];
    logic [1:0]  m_upd;
    int          errs, checks;
    logic        chk_on;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_en = 2'b11; m_per[0] = 32'h0003D090; m_per[1] = 32'h0003D090; m_upd = 2'b00;
    endtask

    // What a well-formed single-DW write to DW index idx must do.
    task automatic model_apply(input logic [5:0] idx, input logic [31:0] d);
        logic [31:0] sw;
        int ch, sub;
        sw = {d[7:0], d[15:8], d[23:16], d[31:24]};
        if (idx >= 8 && idx < 16) begin
            ch = (int'(idx) - 8) / 4;
            sub = (int'(idx) - 8) % 4;
            if (sub == 0) begin m_en[ch] = 1'b1; m_upd[ch] = 1'b1; end
            else if (sub == 1) begin m_en[ch] = 1'b0; m_upd[ch] = 1'b1; end
            else if (sub == 2 && sw != 0) begin m_per[ch] = sw / 4; m_upd[ch] = 1'b1; end
        end
    endtask

    always @(negedge trn_clk) begin
        if (chk_on) begin
            cmp("enables", {30'd0, interrupts_enabled}, {30'd0, m_en});
            cmp("period0", interrupt_period[31:0], m_per[0]);
            cmp("period1", interrupt_period[63:32], m_per[1]);
            cmp("cfg_update", {30'd0, cfg_update}, {30'd0, m_upd});
        end
    end

    task automatic idle(input int n);
        trn_rsrc_rdy_n = 1'b1; trn_rsof_n = 1'b1; trn_reof_n = 1'b1; trn_rsrc_dsc_n = 1'b1;
        repeat (n) begin @(posedge trn_clk); #1; m_upd = 2'b00; end
    endtask

    task automatic beat(input logic [63:0] d, input logic sof, input logic eof, input logic dsc,
                        input int stall, input logic apply, input logic [5:0] idx,
                        input logic [31:0] data);
        trn_rd = d; trn_rsof_n = !sof; trn_reof_n = !eof; trn_rsrc_dsc_n = !dsc;
        trn_rsrc_rdy_n = 1'b0;
        for (int i = 0; i < stall; i++) begin
            trn_rdst_rdy_n = 1'b1;
            @(posedge trn_clk); #1; m_upd = 2'b00;
        end
        trn_rdst_rdy_n = 1'b0;
        @(posedge trn_clk); #1;
        m_upd = 2'b00;
        if (apply) model_apply(idx, data);
        trn_rsrc_rdy_n = 1'b1; trn_rsof_n = 1'b1; trn_reof_n = 1'b1; trn_rsrc_dsc_n = 1'b1;
    endtask

    task automatic send_wr(input logic bar_ok, input logic is64, input logic [9:0] len,
                           input logic [63:0] addr, input logic [31:0] data,
                           input logic dsc_last, input int stall);
        logic [31:0] hdr;
        logic ok;
        hdr = {1'b0, (is64 ? 2'b11 : 2'b10), 5'b0, 14'b0, len};
        ok = bar_ok && (len == 10'd1) && !dsc_last;
        trn_rbar_hit_n = bar_ok ? 7'b1111011 : 7'b1111110;
        beat({hdr, 32'h0000000F}, 1, 0, 0, 0, 0, 6'd0, 32'd0);
        if (!is64) begin
            if (len == 10'd1)
                beat({addr[31:0], data}, 0, 1, dsc_last, stall, ok, addr[7:2], data);
            else begin
                beat({addr[31:0], data}, 0, 0, 0, stall, 0, 6'd0, 32'd0);
                beat({data, 32'd0}, 0, 1, dsc_last, 0, 0, 6'd0, 32'd0);
            end
        end else begin
            beat({addr[63:32], addr[31:0]}, 0, 0, 0, stall, 0, 6'd0, 32'd0);
            beat({data, 32'd0}, 0, 1, dsc_last, 0, ok, addr[7:2], data);
        end
    endtask

    initial begin
        errs = 0; checks = 0; chk_on = 1'b0;
        trn_rd = '0; trn_rrem_n = 8'h00; trn_rsof_n = 1'b1; trn_reof_n = 1'b1;
        trn_rsrc_rdy_n = 1'b1; trn_rsrc_dsc_n = 1'b1; trn_rdst_rdy_n = 1'b0;
        trn_rbar_hit_n = 7'h7F;
        reset_n = 1'b1;
        model_reset();
        #1 reset_n = 1'b0;
        chk_on = 1'b1;
        repeat (3) @(posedge trn_clk);
        #1 reset_n = 1'b1;
        idle(2);
        @(negedge trn_clk);
        cmp("lit_reset_en", {30'd0, interrupts_enabled}, 32'h3);
        cmp("lit_reset_per1", interrupt_period[63:32], 32'h0003D090);

        // ch0 disable: pulse visible the cycle after the data beat, then gone.
        send_wr(1, 0, 10'd1, 64'h24, 32'hDEADBEEF, 0, 0);
        @(negedge trn_clk);
        cmp("lit_dis_en", {30'd0, interrupts_enabled}, 32'h2);
        cmp("lit_dis_pulse", {30'd0, cfg_update}, 32'h1);
        idle(1);
        @(negedge trn_clk);
        cmp("lit_pulse_gone", {30'd0, cfg_update}, 32'h0);
        send_wr(1, 0, 10'd1, 64'h20, 32'h0, 0, 0);
        idle(2);
        cmp("lit_en_back", {30'd0, m_en}, 32'h3);

        // MWr64 period on ch1, upper address ignored.
        send_wr(1, 1, 10'd1, 64'h0000_0001_0000_0038, 32'h00100000, 0, 0);
        idle(2);
        cmp("lit_mwr64_per1", interrupt_period[63:32], 32'h00000400);
        cmp("lit_mwr64_per0", interrupt_period[31:0], 32'h0003D090);

        // Ignored cases: zero period, wrong BAR, length 2, out of range, reserved.
        send_wr(1, 0, 10'd1, 64'h38, 32'h0, 0, 0);           idle(2);
        send_wr(0, 0, 10'd1, 64'h38, 32'h00200000, 0, 0);    idle(2);
        send_wr(1, 0, 10'd2, 64'h38, 32'h00200000, 0, 0);    idle(2);
        send_wr(1, 0, 10'd1, 64'h40, 32'h0, 0, 0);           idle(2);
        send_wr(1, 0, 10'd1, 64'h2C, 32'h0, 0, 0);           idle(2);
        cmp("lit_ignored_per1", interrupt_period[63:32], 32'h00000400);

        // Discontinue on the data beat, 32 and 64-bit.
        send_wr(1, 0, 10'd1, 64'h34, 32'h0, 1, 0);           idle(2);
        send_wr(1, 1, 10'd1, 64'h28, 32'h00200000, 1, 0);    idle(2);
        cmp("lit_dsc_en", {30'd0, interrupts_enabled}, 32'h3);

        // Aliased address (bit 8 set) with stalls: ch0 period.
        send_wr(1, 0, 10'd1, 64'h128, 32'h00200000, 0, 3);   idle(2);
        cmp("lit_stall_per0", interrupt_period[31:0], 32'h00000800);
        send_wr(1, 1, 10'd1, 64'h38, 32'h00300000, 0, 2);    idle(2);
        cmp("lit_stall_per1", m_per[1], 32'h00000C00);

        // Back to back: second SOF lands in the first's COMMIT cycle.
        send_wr(1, 0, 10'd1, 64'h24, 32'h0, 0, 0);
        send_wr(1, 0, 10'd1, 64'h34, 32'h0, 0, 0);
        idle(2);
        cmp("lit_b2b_en", {30'd0, interrupts_enabled}, 32'h0);

        // Reset during the MWr64 data beat.
        trn_rbar_hit_n = 7'b1111011;
        beat({32'h6000_0001, 32'h0000000F}, 1, 0, 0, 0, 0, 6'd0, 32'd0);
        beat({32'h0, 32'h0000_0028}, 0, 0, 0, 0, 0, 6'd0, 32'd0);
        trn_rd = {32'h00400000, 32'h0}; trn_reof_n = 1'b0; trn_rsrc_rdy_n = 1'b0;
        #2 reset_n = 1'b0; model_reset();
        @(posedge trn_clk); #1;
        trn_rsrc_rdy_n = 1'b1; trn_reof_n = 1'b1;
        @(posedge trn_clk); #1 reset_n = 1'b1;
        idle(2);
        cmp("lit_rst_en", {30'd0, interrupts_enabled}, 32'h3);
        cmp("lit_rst_per0", interrupt_period[31:0], 32'h0003D090);
        cmp("lit_rst_per1", interrupt_period[63:32], 32'h0003D090);

        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/intr_cfg_snoop_mc.md
Name: intr_cfg_snoop_mc

Overview:
- Passive snooper on the PCIe TRN RX stream that decodes host posted writes to a BAR and maintains per-channel interrupt enable and interrupt period registers for NUM_CH DMA channels.
- Multi-channel, parametrised successor of the single-channel interrupt enable block.
- Adds MWr64 decoding, length checking, discontinue handling and per-channel update strobes.
- Never drives the TRN interface.

Parameters:
- BAR_IDX, 2, trn_rbar_hit_n bit that selects this block's BAR.
- NUM_CH, 2, number of channels, 1..8; REG_BASE+4*NUM_CH must be <= 64.
- REG_BASE, 8, DW index (addr[7:2]) of channel 0's first register.
- EN_RST, 1'b1, reset value of every enable bit.
- PERIOD_RST, 32'h0003D090, reset value of every period register.

Ports:
- trn_clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- trn_rd  in  64  RX data; DW0 in [63:32].
- trn_rrem_n  in  8  RX remainder; ignored except as noted.
- trn_rsof_n  in  1  start of frame, active-low.
- trn_reof_n  in  1  end of frame, active-low.
- trn_rsrc_rdy_n  in  1  source ready, active-low.
- trn_rsrc_dsc_n  in  1  source discontinue, active-low.
- trn_rbar_hit_n  in  7  BAR hit, active-low.
- trn_rdst_rdy_n  in  1  destination ready, active-low (observed only).
- interrupts_enabled  out  NUM_CH  per-channel enable.
- interrupt_period  out  32*NUM_CH  channel c occupies bits [32c+31:32c].
- cfg_update  out  NUM_CH  one-cycle pulse per channel whose register was written.

Behaviour:
- Beat accepted = !trn_rsrc_rdy_n && !trn_rdst_rdy_n. All decoding uses accepted beats only.
- Reset values: interrupts_enabled = all EN_RST; every period = PERIOD_RST; cfg_update = 0; FSM = IDLE.
- Reset asserted mid-TLP aborts the TLP with no register update.

Register map (idx = addr[7:2]; addr bits above 7 and the MWr64 upper address are ignored, so aliasing is permitted):
- Registers occupy REG_BASE <= idx < REG_BASE+4*NUM_CH.
- Decode: ch = (idx-REG_BASE)>>2, sub = (idx-REG_BASE)&3.
- sub 0: enable (data ignored).
- sub 1: disable (data ignored).
- sub 2: period.
- sub 3: reserved, ignored.

FSM:
- IDLE: on an accepted SOF beat with !trn_rbar_hit_n[BAR_IDX]:
  - fmt/type trn_rd[62:56] = 7'b10_00000 (MWr32) or 7'b11_00000 (MWr64), and length trn_rd[41:32] = 1 -> go to ADDR and latch is64.
  - Any other SOF beat that is not also EOF -> go to DRAIN.
- ADDR (next accepted beat):
  - MWr32: address in [63:32], data in [31:0]. This beat must carry EOF; latch both and go to COMMIT.
  - MWr64: address low in [31:0]; latch it and go to DATA.
- DATA (next accepted beat): data in [63:32]; latch it and go to COMMIT.
- COMMIT (exactly one cycle):
  - Apply the decoded action and pulse cfg_update[ch].
  - Also performs IDLE's SOF detection, so back-to-back TLPs are not missed.
- DRAIN: wait for an accepted EOF beat, then go to IDLE.
- Discontinue: an accepted beat with !trn_rsrc_dsc_n -> go to IDLE, no update.
- Unexpected EOF before the data beat -> go to IDLE, no update.
- Unexpected SOF in ADDR/DATA -> treat as a new TLP from IDLE.

Period write:
- Payload is byte-swapped: sw = {d[7:0], d[15:8], d[23:16], d[31:24]}.
- If sw == 0: no update and no cfg_update pulse.
- Otherwise: period[ch] <= {2'b00, sw[31:2]} (byte count converted to 4-byte units).

Latency: a register and its cfg_update pulse are visible the clock edge after the data beat is accepted.

Enable/disable:
- Apply even if already in that state.
- cfg_update still pulses.
- Other channels are untouched.

Test Plan:
- Reset, then idle -> interrupts_enabled = 2'b11, both periods = 0x3D090, cfg_update = 0.
- MWr32, BAR2, addr 0x24 (idx 9 = ch0 disable) -> interrupts_enabled = 2'b10, cfg_update = 2'b01 for one cycle, one edge after the data beat; then addr 0x20 -> 2'b11.
- MWr64, addr 0x0000_0001_0000_0038 (idx 14 = ch1 period), data 0x00100000 on the wire (sw = 0x00001000) -> period[ch1] = 0x400, ch0 unchanged.
- Period write with data 0 -> no change, no pulse. Same write on BAR0 -> ignored. Length 2 -> ignored and drained.
- Data beat with trn_rsrc_dsc_n low -> no update. Also: trn_rdst_rdy_n high stall cycles inserted mid-TLP -> result identical to the unstalled case.
- Two back-to-back MWr32 TLPs, the second's SOF in the first's COMMIT cycle (ch0 disable, then ch1 disable) -> both applied, final 2'b00. Reset asserted during a DATA beat -> reset values, no update.
